// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/gnt/rvalid data bus; define MEM_TIMEOUT_EN to add a bus-timeout abort
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] rd_data2_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  exc_o,
  output logic [1:0]            exc_cause_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, data_q;
  logic [2:0]            f3_q;
  logic                  we_q, exc_q;
  logic [1:0]            cause_q;
  logic                  start, illegal, misalign, tmo, done;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [DATA_WIDTH-1:0] ext;
  assign start    = MemRead_i | MemWrite_i;
  assign illegal  = MemWrite_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
                               : ((funct3_i == 3'd3) | (funct3_i[2:1] == 2'b11));
  assign misalign = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0]));
  assign b   = addr_q[1] ? (addr_q[0] ? dmem_rdata_i[31:24] : dmem_rdata_i[23:16])
                         : (addr_q[0] ? dmem_rdata_i[15:8]  : dmem_rdata_i[7:0]);
  assign h   = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign ext = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & b[7]}}, b} :
               (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & h[15]}}, h} : dmem_rdata_i;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // bus-wait cycle counter, cleared whenever the unit is not waiting on the bus
  always_ff @(posedge clk_i)
    cnt_q <= (rst_i || !(state_q == REQ || state_q == WAIT_R)) ? '0 : cnt_q + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // access sequencer: latch the instruction, run one bus transaction, report in DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= alu_result_i;
          wdata_q <= rd_data2_i;
          f3_q    <= funct3_i;
          we_q    <= MemWrite_i;
          data_q  <= '0;
          exc_q   <= illegal | misalign;
          cause_q <= illegal ? 2'd3 : {1'b0, MemWrite_i};
          state_q <= (illegal | misalign) ? DONE : REQ;
        end
        REQ: if (dmem_gnt_i) state_q <= we_q ? DONE : WAIT_R;
          else if (tmo) begin
            exc_q   <= 1'b1;
            cause_q <= 2'd2;
            state_q <= DONE;
          end
        WAIT_R: if (dmem_rvalid_i) begin
            data_q  <= ext;
            state_q <= DONE;
          end else if (tmo) begin
            exc_q   <= 1'b1;
            cause_q <= 2'd2;
            state_q <= DONE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done         = state_q == DONE;
  assign stall_o      = ~rst_i & ((state_q == REQ) | (state_q == WAIT_R) | ((state_q == IDLE) & start));
  assign dmem_req_o   = state_q == REQ;
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be_o    = !dmem_req_o ? 4'b0000 :
                        (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                        (f3_q[1:0] == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dmem_wdata_o = !dmem_req_o ? '0 :
                        (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                        (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
  assign load_valid_o = done & ~we_q & ~exc_q;
  assign load_data_o  = load_valid_o ? data_q : '0;
  assign exc_o        = done & exc_q;
  assign exc_cause_o  = exc_o ? cause_q : 2'd0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of stores, loads, exceptions, delayed grant, reset abort and timeout
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1, mr = 1'b0, mw = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] alu = '0, rs2 = '0, rdata = '0;
  logic        stall_o, load_valid_o, exc_o, dmem_req_o, dmem_we_o;
  logic [1:0]  exc_cause_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] load_data_o, dmem_addr_o, dmem_wdata_o;
  int checks = 0, failures = 0;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr), .MemWrite_i(mw), .funct3_i(f3),
    .alu_result_i(alu), .rd_data2_i(rs2), .stall_o(stall_o), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mr  = 1'b1;
    repeat (2) tick;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, load_valid_o, exc_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {stall_o, dmem_req_o, load_valid_o, exc_o});
    end
    checks++;
    if ({load_data_o, exc_cause_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h/%b exp=all zero", load_data_o, exc_cause_o,
               dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o);
    end
    tick;
    rst = 1'b0;
    mr  = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_stall got=%b exp=0", stall_o);
    end
  endtask

  task automatic test_store_byte;
    tick;
    mw = 1'b1; f3 = 3'd0; alu = 32'h1003; rs2 = 32'h000000A5;
    #1;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b10) begin
      failures++;
      $display("FAIL sb_idle got stall/req=%b exp=10", {stall_o, dmem_req_o});
    end
    tick;
    gnt = 1'b1;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
        {3'b111, 32'h00001000, 4'b1000, 32'hA5A5A5A5}) begin
      failures++;
      $display("FAIL sb_req got st/rq/we=%b addr=%h be=%b wd=%h exp 111 00001000 1000 a5a5a5a5",
               {stall_o, dmem_req_o, dmem_we_o}, dmem_addr_o, dmem_be_o, dmem_wdata_o);
    end
    tick;
    gnt = 1'b0;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, load_valid_o, exc_o} !== 4'b0000) begin
      failures++;
      $display("FAIL sb_done got st/rq/lv/exc=%b exp=0000", {stall_o, dmem_req_o, load_valid_o, exc_o});
    end
    tick;
    mw = 1'b0;
    #1;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b00) begin
      failures++;
      $display("FAIL sb_after got stall/req=%b exp=00", {stall_o, dmem_req_o});
    end
  endtask

  task automatic test_load(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp);
    tick;
    mr = 1'b1; f3 = fn; alu = a;
    #1;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b10) begin
      failures++;
      $display("FAIL ld_idle f3=%0d got stall/req=%b exp=10", fn, {stall_o, dmem_req_o});
    end
    tick;
    gnt = 1'b1;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o} !== {3'b110, a[31:2], 2'b00}) begin
      failures++;
      $display("FAIL ld_req f3=%0d got st/rq/we=%b addr=%h exp 110 %h", fn,
               {stall_o, dmem_req_o, dmem_we_o}, dmem_addr_o, {a[31:2], 2'b00});
    end
    tick;
    gnt = 1'b0; rvalid = 1'b1; rdata = rd;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, load_valid_o} !== 3'b100) begin
      failures++;
      $display("FAIL ld_wait f3=%0d got st/rq/lv=%b exp=100", fn, {stall_o, dmem_req_o, load_valid_o});
    end
    tick;
    rvalid = 1'b0; rdata = '0;
    #1;
    checks++;
    if ({stall_o, load_valid_o, exc_o, load_data_o} !== {3'b010, exp}) begin
      failures++;
      $display("FAIL ld_done f3=%0d addr=%h got st/lv/exc=%b data=%h exp 010 %h", fn, a,
               {stall_o, load_valid_o, exc_o}, load_data_o, exp);
    end
    tick;
    mr = 1'b0;
    #1;
    checks++;
    if ({load_valid_o, load_data_o} !== 33'd0) begin
      failures++;
      $display("FAIL ld_after got lv=%b data=%h exp 0 0", load_valid_o, load_data_o);
    end
  endtask

  task automatic test_exception(input logic we, input logic [2:0] fn, input logic [31:0] a,
                                input logic [1:0] cause);
    tick;
    mw = we; mr = ~we; f3 = fn; alu = a; rs2 = 32'hDEADBEEF;
    #1;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b10) begin
      failures++;
      $display("FAIL exc_idle f3=%0d got stall/req=%b exp=10", fn, {stall_o, dmem_req_o});
    end
    tick;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, load_valid_o, exc_o, exc_cause_o, load_data_o} !== {4'b0001, cause, 32'd0}) begin
      failures++;
      $display("FAIL exc_done f3=%0d got st/rq/lv/exc=%b cause=%0d data=%h exp 0001 cause=%0d 0", fn,
               {stall_o, dmem_req_o, load_valid_o, exc_o}, exc_cause_o, load_data_o, cause);
    end
    tick;
    mw = 1'b0; mr = 1'b0;
    #1;
    checks++;
    if ({exc_o, exc_cause_o, dmem_req_o} !== 4'b0) begin
      failures++;
      $display("FAIL exc_after got exc=%b cause=%0d req=%b exp 0 0 0", exc_o, exc_cause_o, dmem_req_o);
    end
  endtask

  task automatic test_delayed_gnt;
    int reqs = 0;
    tick;
    mw = 1'b1; f3 = 3'd2; alu = 32'h4008; rs2 = 32'hCAFEF00D;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick;
      gnt = (k == 3);
      #1;
      reqs += dmem_req_o ? 1 : 0;
      checks++;
      if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
          {3'b111, 32'h00004008, 4'b1111, 32'hCAFEF00D}) begin
        failures++;
        $display("FAIL sw_req cycle=%0d got st/rq/we=%b addr=%h be=%b wd=%h exp 111 00004008 1111 cafef00d",
                 k, {stall_o, dmem_req_o, dmem_we_o}, dmem_addr_o, dmem_be_o, dmem_wdata_o);
      end
    end
    tick;
    #1;
    reqs += dmem_req_o ? 1 : 0;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b00) begin
      failures++;
      $display("FAIL sw_done got stall/req=%b exp=00", {stall_o, dmem_req_o});
    end
    tick;
    gnt = 1'b0; mw = 1'b0;
    #1;
    reqs += dmem_req_o ? 1 : 0;
    checks++;
    if (reqs !== 4) begin
      failures++;
      $display("FAIL sw_req_count got=%0d exp=4", reqs);
    end
  endtask

  task automatic test_reset_mid_load;
    tick;
    mr = 1'b1; f3 = 3'd2; alu = 32'h5000;
    #1;
    tick;
    gnt = 1'b1;
    #1;
    tick;
    gnt = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait got stall/req=%b exp=00", {stall_o, dmem_req_o});
    end
    tick;
    rst = 1'b0; mr = 1'b0;
    #1;
    tick;
    rvalid = 1'b1; rdata = 32'h55AA55AA;
    #1;
    tick;
    rvalid = 1'b0;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, load_valid_o, exc_o, load_data_o} !== 36'd0) begin
      failures++;
      $display("FAIL rst_late_rvalid got st/rq/lv/exc=%b data=%h exp 0000 0",
               {stall_o, dmem_req_o, load_valid_o, exc_o}, load_data_o);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    tick;
    mr = 1'b1; f3 = 3'd2; alu = 32'h3000;
    #1;
    tick;
    gnt = 1'b1;
    #1;
    while (stall_o && n < 20) begin
      n++;
      tick;
      gnt = 1'b0;
      #1;
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d exp=8", n);
    end
    checks++;
    if ({dmem_req_o, load_valid_o, exc_o, exc_cause_o, load_data_o} !== {5'b00110, 32'd0}) begin
      failures++;
      $display("FAIL timeout_exc got rq/lv/exc=%b cause=%0d data=%h exp 001 2 0",
               {dmem_req_o, load_valid_o, exc_o}, exc_cause_o, load_data_o);
    end
    tick;
    mr = 1'b0;
    #1;
  endtask
`endif

  initial begin
    test_reset;
    test_store_byte;
    test_load(3'd0, 32'h2001, 32'h123480FF, 32'hFFFFFF80);
    test_load(3'd4, 32'h2001, 32'h123480FF, 32'h00000080);
    test_load(3'd1, 32'h2002, 32'h123480FF, 32'h00001234);
    test_load(3'd1, 32'h2000, 32'h123480FF, 32'hFFFF80FF);
    test_load(3'd5, 32'h2000, 32'h123480FF, 32'h000080FF);
    test_load(3'd0, 32'h2003, 32'h123480FF, 32'h00000012);
    test_load(3'd2, 32'h2000, 32'h123480FF, 32'h123480FF);
    test_exception(1'b0, 3'd2, 32'h2002, 2'd0);
    test_exception(1'b1, 3'd1, 32'h2001, 2'd1);
    test_exception(1'b0, 3'd3, 32'h2000, 2'd3);
    test_exception(1'b1, 3'd4, 32'h2000, 2'd3);
    test_delayed_gnt;
    test_reset_mid_load;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
